// File: rtl/de10boy_pkg.sv
// rtl/de10boy_pkg.sv - shared timing constants, ppu mode encoding and palette for de10boy
package de10boy_pkg;

  localparam int LINE_CYCLES  = 456;
  localparam int LINES        = 154;
  localparam int FRAME_CYCLES = 70224;
  localparam int CYC_W        = $clog2(FRAME_CYCLES);
  localparam int OAM_END      = 80;
  localparam int DRAW_END     = 252;
  localparam int VBLANK_LINE  = 144;
  localparam int SCREEN_W     = 160;
  localparam int FB_DEPTH     = SCREEN_W * VBLANK_LINE;
  localparam int FB_AW        = $clog2(FB_DEPTH);

  localparam int H_TOTAL      = 800;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int WIN_H_START  = 80;
  localparam int WIN_H_END    = 560;
  localparam int WIN_V_START  = 24;
  localparam int WIN_V_END    = 456;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_e;

  function automatic logic [3:0] palette(input logic [1:0] shade);
    case (shade)
      2'd0:    palette = 4'hF;
      2'd1:    palette = 4'hA;
      2'd2:    palette = 4'h5;
      default: palette = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/de10boy_fb.sv
// rtl/de10boy_fb.sv - 23040x2 simple dual-port framebuffer, registered read returning old data on collision
module de10boy_fb
  import de10boy_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [1:0]       wr_data,
  input  logic [FB_AW-1:0] rd_addr,
  output logic [1:0]       rd_data
);

  logic [1:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/de10boy.sv
// rtl/de10boy.sv - de10boy top: cpu-rate tick, ppu timing/pattern renderer, upscaled vga scan-out
module de10boy
  import de10boy_pkg::*;
#(
  parameter int CPU_DIV = 5,
  parameter int SCALE   = 3
) (
  input  logic       Clk,
  input  logic [1:0] KEY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B
);

  localparam int DIV_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  logic             reset;
  logic             scroll_btn;
  logic             clock;
  logic             memclock;
  logic [DIV_W-1:0] divider;
  logic             fb_we;
  logic [FB_AW-1:0] fb_waddr;
  logic [1:0]       fb_wdata;
  logic [FB_AW-1:0] fb_raddr;
  logic [1:0]       fb_rdata;

  assign reset      = ~KEY[0];
  assign scroll_btn = ~KEY[1];
  assign memclock   = Clk;
  assign clock      = (divider == DIV_W'(CPU_DIV - 1));

  always_ff @(posedge Clk) begin
    if (reset || clock) divider <= '0;
    else                divider <= divider + DIV_W'(1);
  end

  if (1) begin : ppu
    logic [8:0]       line_cycles;
    logic [9:0]       y;
    logic [CYC_W-1:0] cycles;
    ppu_mode_e        ppu_mode;
    logic [5:0]       render_state;
    logic             x_valid;
    logic [9:0]       x;
    logic [7:0]       scroll_x, scroll_y, bg_x, bg_y;
    logic [5:0]       bg_tile_x, bg_tile_y;
    logic [4:0]       tile_x, tile_y;
    logic [1:0]       shade;
    logic             line_end, frame_end;
    logic             unused_debug;

    assign line_end  = (line_cycles == 9'(LINE_CYCLES - 1));
    assign frame_end = line_end && (y == 10'(LINES - 1));

    always_ff @(posedge Clk) begin
      if (reset) begin
        line_cycles <= '0;
        y           <= '0;
        cycles      <= '0;
        scroll_x    <= '0;
        scroll_y    <= '0;
      end else if (clock) begin
        line_cycles <= line_end ? '0 : line_cycles + 9'd1;
        cycles      <= frame_end ? '0 : cycles + CYC_W'(1);
        if (line_end) y <= frame_end ? '0 : y + 10'd1;
        // scroll steps exactly once per frame, on entry to vblank
        if (line_end && y == 10'(VBLANK_LINE - 1) && scroll_btn) begin
          scroll_x <= scroll_x + 8'd1;
          scroll_y <= scroll_y + 8'd1;
        end
      end
    end

    always_comb begin
      x_valid = (y < 10'(VBLANK_LINE)) && (line_cycles >= 9'(OAM_END))
             && (line_cycles < 9'(OAM_END + SCREEN_W));
      x = x_valid ? 10'(line_cycles - 9'(OAM_END)) : '0;
      if (y >= 10'(VBLANK_LINE))           ppu_mode = MODE_VBLANK;
      else if (line_cycles < 9'(OAM_END))  ppu_mode = MODE_OAM;
      else if (line_cycles < 9'(DRAW_END)) ppu_mode = MODE_DRAW;
      else                                 ppu_mode = MODE_HBLANK;
      case (ppu_mode)
        MODE_OAM:    render_state = 6'd0;
        MODE_DRAW:   render_state = 6'd1;
        MODE_HBLANK: render_state = 6'd2;
        default:     render_state = 6'd3;
      endcase
    end

    assign bg_x      = x[7:0] + scroll_x;
    assign bg_y      = y[7:0] + scroll_y;
    assign bg_tile_x = {1'b0, bg_x[7:3]};
    assign bg_tile_y = {1'b0, bg_y[7:3]};
    assign tile_x    = {2'b00, bg_x[2:0]};
    assign tile_y    = {2'b00, bg_y[2:0]};
    assign shade     = {bg_tile_x[0] ^ bg_tile_y[0], tile_x[2] ^ tile_y[2]};

    assign fb_we     = clock && x_valid;
    assign fb_waddr  = FB_AW'(y) * FB_AW'(SCREEN_W) + FB_AW'(x);
    assign fb_wdata  = shade;
    assign unused_debug = ^{render_state, bg_tile_x, bg_tile_y, tile_x, tile_y};
  end

  de10boy_fb framebuffer (
    .clk     (memclock),
    .wr_en   (fb_we),
    .wr_addr (fb_waddr),
    .wr_data (fb_wdata),
    .rd_addr (fb_raddr),
    .rd_data (fb_rdata)
  );

  logic             pix_en;
  logic [9:0]       hc, vc;
  logic             hs_now, vs_now, win_now;
  logic             hs_d, vs_d, win_d;
  logic [FB_AW-1:0] rd_addr_now;
  logic [3:0]       level;

  always_comb begin
    hs_now  = !(hc >= 10'(H_SYNC_START) && hc < 10'(H_SYNC_END));
    vs_now  = !(vc >= 10'(V_SYNC_START) && vc < 10'(V_SYNC_END));
    win_now = (hc >= 10'(WIN_H_START)) && (hc < 10'(WIN_H_END))
           && (vc >= 10'(WIN_V_START)) && (vc < 10'(WIN_V_END));
    rd_addr_now = '0;
    if (win_now)
      rd_addr_now = FB_AW'((vc - 10'(WIN_V_START)) / 10'(SCALE)) * FB_AW'(SCREEN_W)
                  + FB_AW'((hc - 10'(WIN_H_START)) / 10'(SCALE));
  end

  // stage 1 latches address and syncs, the RAM reads on the in-between edge, stage 2 drives pins
  always_ff @(posedge Clk) begin
    if (reset) begin
      pix_en   <= 1'b0;
      hc       <= '0;
      vc       <= '0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      win_d    <= 1'b0;
      fb_raddr <= '0;
      VGA_HS   <= 1'b1;
      VGA_VS   <= 1'b1;
      level    <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hc == 10'(H_TOTAL - 1)) begin
          hc <= '0;
          vc <= (vc == 10'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
        hs_d     <= hs_now;
        vs_d     <= vs_now;
        win_d    <= win_now;
        fb_raddr <= rd_addr_now;
        VGA_HS   <= hs_d;
        VGA_VS   <= vs_d;
        level    <= win_d ? palette(fb_rdata) : 4'h0;
      end
    end
  end

  assign VGA_R = level;
  assign VGA_G = level;
  assign VGA_B = level;

endmodule

// File: tb/tb_de10boy.sv
// tb/tb_de10boy.sv - randomized bench comparing de10boy against a tick-count frame model
module tb_de10boy;

  localparam int FRAME_T = 154 * 456;
  localparam int VBL_T   = 144 * 456;
  localparam int END_T   = FRAME_T + 87;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic       hs, vs, hs5, vs5;
  logic [3:0] r, g, b, r5, g5, b5;

  int passed = 0;
  int total  = 0;

  bit   tracking = 0;
  int   ohc, ovc, ph, low_cnt;
  logic prev_hs;

  always #10 clk = ~clk;

  de10boy #(.CPU_DIV(1), .SCALE(3)) dut (
    .Clk(clk), .KEY(key), .VGA_HS(hs), .VGA_VS(vs), .VGA_R(r), .VGA_G(g), .VGA_B(b)
  );

  de10boy dut5 (
    .Clk(clk), .KEY(key), .VGA_HS(hs5), .VGA_VS(vs5), .VGA_R(r5), .VGA_G(g5), .VGA_B(b5)
  );

  task automatic check(input string tag, input int at, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at=%0d observed=%0h expected=%0h", tag, at, obs, exp);
  endtask

  function automatic int exp_shade(input int px, input int py, input int sc);
    int bx = (px + sc) % 256;
    int by = (py + sc) % 256;
    return (((bx / 8) ^ (by / 8)) & 1) * 2 + (((bx / 4) ^ (by / 4)) & 1);
  endfunction

  function automatic int pal(input int s);
    case (s)
      0:       return 15;
      1:       return 10;
      2:       return 5;
      default: return 0;
    endcase
  endfunction

  task automatic check_ppu(input int t, input int sc);
    int lc = t % 456;
    int ln = (t / 456) % 154;
    int xe, mode, rs;
    xe = (ln < 144 && lc >= 80 && lc < 240) ? lc - 80 : 0;
    if (ln >= 144)     begin mode = 1; rs = 3; end
    else if (lc < 80)  begin mode = 2; rs = 0; end
    else if (lc < 252) begin mode = 3; rs = 1; end
    else               begin mode = 0; rs = 2; end
    check("line_cycles",  t, dut.ppu.line_cycles,  lc);
    check("y",            t, dut.ppu.y,            ln);
    check("cycles",       t, dut.ppu.cycles,       t % FRAME_T);
    check("ppu_mode",     t, dut.ppu.ppu_mode,     mode);
    check("render_state", t, dut.ppu.render_state, rs);
    check("x",            t, dut.ppu.x,            xe);
    check("scroll_x",     t, dut.ppu.scroll_x,     sc);
    check("scroll_y",     t, dut.ppu.scroll_y,     sc);
    check("shade",        t, dut.ppu.shade,        exp_shade(xe, ln, sc));
  endtask

  task automatic vga_pixel();
    int exp_lvl = 0;
    int at = ovc * 800 + ohc;
    if (ohc >= 80 && ohc < 560 && ovc >= 24 && ovc < 456)
      exp_lvl = pal(exp_shade((ohc - 80) / 3, (ovc - 24) / 3, 0));
    check("vga_hs",  at, hs, (ohc >= 656 && ohc < 752) ? 0 : 1);
    check("vga_vs",  at, vs, (ovc >= 490 && ovc < 492) ? 0 : 1);
    check("vga_rgb", at, {r, g, b}, exp_lvl * 32'h111);
    if (ohc == 80 && ovc == 24) check("pix_80_24", at, {r, g, b}, 32'hFFF);
    if (hs === 1'b0) low_cnt++;
    if (ohc == 799) begin
      check("hs_low_per_line", at, low_cnt, 96);
      low_cnt = 0;
    end
  endtask

  task automatic vga_step();
    if (!tracking) begin
      if (prev_hs === 1'b1 && hs === 1'b0) begin
        tracking = 1;
        ohc = 656; ovc = 0; ph = 0; low_cnt = 0;
        vga_pixel();
      end
    end else begin
      ph ^= 1;
      if (ph == 0) begin
        ohc++;
        if (ohc == 800) begin ohc = 0; ovc++; end
        if (ovc < 30) vga_pixel();
      end
    end
    prev_hs = hs;
  endtask

  initial begin
    int n;
    int m;
    key = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    check("rst_line_cycles",  0, dut.ppu.line_cycles,  0);
    check("rst_y",            0, dut.ppu.y,            0);
    check("rst_cycles",       0, dut.ppu.cycles,       0);
    check("rst_ppu_mode",     0, dut.ppu.ppu_mode,     2);
    check("rst_render_state", 0, dut.ppu.render_state, 0);
    check("rst_x",            0, dut.ppu.x,            0);
    check("rst_scroll",       0, {dut.ppu.scroll_x, dut.ppu.scroll_y}, 0);
    check("rst_divider",      0, dut5.divider,         0);
    check("rst_sync",         0, {hs, vs},             2'b11);
    check("rst_rgb",          0, {r, g, b},            0);

    key[0]  = 1'b1;
    key[1]  = 1'($urandom_range(0, 1));
    prev_hs = hs;
    for (int t = 1; t <= END_T; t++) begin
      @(posedge clk);
      #1;
      check_ppu(t, (t >= VBL_T) ? 1 : 0);
      vga_step();
      if (t == 3) begin
        check("div5_tick_early", t, dut5.clock, 0);
        check("div5_lc_early",   t, dut5.ppu.line_cycles, 0);
      end
      if (t == 4) begin
        check("div5_tick",    t, dut5.clock, 1);
        check("div5_lc_hold", t, dut5.ppu.line_cycles, 0);
      end
      if (t == 5) begin
        check("div5_first_step", t, dut5.ppu.line_cycles, 1);
        check("div5_tick_clear", t, dut5.clock, 0);
      end
      if (t == 10) check("div5_second_step", t, dut5.ppu.line_cycles, 2);
      if (t == VBL_T + 36) begin
        for (int a = 0; a < 23040; a++)
          check("fb_frame0", a, dut.framebuffer.mem[a], exp_shade(a % 160, a / 160, 0));
      end
      if (t == END_T) begin
        check("scroll_bg_tile_x", t, dut.ppu.bg_tile_x, 1);
        check("scroll_tile_x",    t, dut.ppu.tile_x,    0);
        check("scroll_shade",     t, dut.ppu.shade,     2'b10);
      end
      key[1] = (t >= VBL_T - 14 && t <= VBL_T + 6) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    check("hs_fall_seen",  END_T, tracking, 1);
    check("vga_lines_run", END_T, (ovc >= 30) ? 1 : 0, 1);

    key[0] = 1'b0;
    n = $urandom_range(1, 6);
    repeat (n) @(posedge clk);
    #1;
    check("mid_rst_line_cycles", n, dut.ppu.line_cycles, 0);
    check("mid_rst_y",           n, dut.ppu.y,           0);
    check("mid_rst_cycles",      n, dut.ppu.cycles,      0);
    check("mid_rst_scroll",      n, {dut.ppu.scroll_x, dut.ppu.scroll_y}, 0);
    check("mid_rst_ppu_mode",    n, dut.ppu.ppu_mode,    2);
    check("mid_rst_sync",        n, {hs, vs},            2'b11);
    check("mid_rst_rgb",         n, {r, g, b},           0);
    key[0] = 1'b1;
    m = $urandom_range(100, 600);
    for (int t = 1; t <= m; t++) begin
      @(posedge clk);
      #1;
      check_ppu(t, 0);
      key[1] = 1'($urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/de10boy.md
DE10BOY -- requirements
Module: de10boy

Interface
REQ-001 Parameter CPU_DIV, default 5: Clk cycles per CPU-rate tick.
REQ-002 Parameter SCALE, default 3: integer VGA upscale factor for the 160x144 image.
REQ-003 Clk  input  1  system clock, 50 MHz; the only clock; all state on rising edge.
REQ-004 KEY  input  2  KEY[0] active-low reset button, KEY[1] active-low scroll button.
REQ-005 Internal reset = NOT KEY[0]; reset is synchronous and active-high.
REQ-006 VGA_HS  output  1  horizontal sync, active low.
REQ-007 VGA_VS  output  1  vertical sync, active low.
REQ-008 VGA_R, VGA_G, VGA_B  output  4 each  colour channels.

Function
REQ-009 Internal signal clock: 1-Clk-wide tick when divider (0..CPU_DIV-1) reaches CPU_DIV-1; memclock = Clk.
REQ-010 PPU advances only on clock ticks.
REQ-011 line_cycles (9 bit): 0..455, wraps to 0.
REQ-012 y (10 bit): increments when line_cycles wraps; 0..153, wraps to 0.
REQ-013 cycles (17 bit): 0..70223, wraps to 0 together with y wrapping.
REQ-014 ppu_mode (2 bit): y>=144 -> 1; else line_cycles<80 -> 2; <252 -> 3; else 0.
REQ-015 render_state (6 bit): 0 OAM, 1 DRAW, 2 HBLANK, 3 VBLANK; tracks ppu_mode.
REQ-016 x (10 bit) = line_cycles-80 while 80<=line_cycles<240 and y<144; x is 0 otherwise.
REQ-017 bgX = (x+scrollX) mod 256, bgY = (y+scrollY) mod 256.
REQ-018 bgTileX = bgX[7:3], bgTileY = bgY[7:3], zero-extended to 6 bit.
REQ-019 tileX = bgX[2:0], tileY = bgY[2:0], zero-extended to 5 bit.
REQ-020 Shade (2 bit) = {bgTileX[0]^bgTileY[0], tileX[2]^tileY[2]}.
REQ-021 On each tick with a valid x (REQ-016), write the shade to framebuffer address y*160+x.
REQ-022 scrollX, scrollY: 8-bit registers.
REQ-023 On the tick where y becomes 144, if KEY[1]=0, scrollY increments by 1 and scrollX by 1, both mod 256.
REQ-024 VGA pixel enable: every 2nd Clk.
REQ-025 VGA horizontal: total 800; visible 0..639; HS low 656..751.
REQ-026 VGA vertical: total 525; visible 0..479; VS low 490..491.
REQ-027 Image window: h 80..559, v 24..455.
REQ-028 Window pixel = framebuffer[(vc-24)/SCALE][(hc-80)/SCALE].
REQ-029 Outside window or blanking: RGB = 0.
REQ-030 Palette, all three channels equal: shade 0 -> F, 1 -> A, 2 -> 5, 3 -> 0.
REQ-031 VGA outputs registered; RGB aligned to HS/VS; framebuffer read latency 1 pixel, compensated by delaying syncs.
REQ-032 Simultaneous PPU write and VGA read of one address: read returns the old data.

Reset
REQ-033 While reset=1, zero all counters, scrollX, scrollY, divider, x.
REQ-034 While reset=1: ppu_mode=2, render_state=0, VGA_HS=VGA_VS=1, RGB=0.
REQ-035 Framebuffer contents are not cleared by reset.
REQ-036 Reset asserted mid-frame restarts at y=0, line_cycles=0 on the first tick after release.

Structure
REQ-037 Package de10boy_pkg holds: LINE_CYCLES=456, LINES=154, FRAME_CYCLES=70224, mode-boundary constants (80, 252, 144), VGA timing constants, ppu_mode enum, palette function.
REQ-038 One sub-module de10boy_fb: single-clock simple dual-port RAM, 23040x2, registered read.
REQ-039 Hierarchy instance names: ppu (timing/render logic, exposing the REQ-011..REQ-022 signals), clock, memclock.

Verification
REQ-040 Reset: hold KEY[0]=0 for 4 Clk, release -> cycles=0, y=0, ppu_mode=2; first tick after 5 Clk.
REQ-041 Line timing: line_cycles 79->80 -> ppu_mode 2->3; 251->252 -> 0; 455 -> line_cycles 0, y+1.
REQ-042 VBlank: y=144 -> ppu_mode=1, render_state=3; after y=153/line_cycles=455 -> y=0, cycles=0 (70224 ticks/frame).
REQ-043 Scroll: KEY[1]=0 across one VBlank entry -> scrollX=scrollY=1; at x=7,y=0 -> bgTileX=1, tileX=0, shade=2'b10.
REQ-044 VGA: HS low 96 pixel clocks per 800; VS low 2 lines per 525; pixel (80,24) = framebuffer(0,0) shade 0 -> RGB F,F,F; pixel (0,0) -> RGB 0.
